// File: rtl/jk_pkg.sv
// Shared state encoding and default sizing for the JK bank driver.
package jk_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StCheck = 2'd2,
    StResp  = 2'd3
  } jk_state_e;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: the J/K pair that moves each flop from q to target in one edge.
module jk_excite #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] target,
  input  logic             use_toggle,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    if (use_toggle) begin
      j = q ^ target;
      k = q ^ target;
    end else begin
      // Don't-care inputs resolved to 0: only the bit that must change is driven.
      j = ~q & target;
      k = q & ~target;
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Loads a target vector into an external JK flip-flop bank and reports whether Q followed.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          USE_TOGGLE = 1'b0
) (
  input  logic             CP,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  jk_state_e        state_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .q         (q_in),
    .target    (tgt_data),
    .use_toggle(USE_TOGGLE),
    .j         (exc_j),
    .k         (exc_k)
  );

  assign tgt_ready = (state_q == StIdle);

  always_ff @(posedge CP) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      j_out    <= '0;
      k_out    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      mismatch <= '0;
    end else begin
      // J/K default to zero so the bank holds outside the single DRIVE cycle.
      j_out <= '0;
      k_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tgt_valid) begin
            target_q <= tgt_data;
            j_out    <= exc_j;
            k_out    <= exc_k;
            state_q  <= StDrive;
          end
        end
        StDrive: state_q <= StCheck;
        StCheck: begin
          mismatch <= q_in ^ target_q;
          state_q  <= StResp;
        end
        StResp: begin
          done    <= (mismatch == '0);
          err     <= (mismatch != '0);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle style), each with a modelled JK bank.
module tb_jk_bank_driver;

  logic       CP = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic [3:0] tgt_data;
  logic       tgt_ready, tgt_ready_t;
  logic [3:0] j_out, k_out, j_t, k_t;
  logic       done, err, done_t, err_t;
  logic [3:0] mismatch, mismatch_t;

  logic [3:0] bank_q, bank_q_t;
  logic       bank_load;
  logic [3:0] load_val;
  logic [3:0] stuck_mask;
  logic [3:0] q_in, q_in_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CP = ~CP;

  // Bank models: edge-triggered JK flops, preloadable, with stuck-at-0 readback on the main bank.
  always @(posedge CP) begin
    if (bank_load) begin
      bank_q   <= load_val;
      bank_q_t <= load_val;
    end else begin
      bank_q   <= (j_out & ~bank_q) | (~k_out & bank_q);
      bank_q_t <= (j_t & ~bank_q_t) | (~k_t & bank_q_t);
    end
  end
  assign q_in   = bank_q & ~stuck_mask;
  assign q_in_t = bank_q_t;

  jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) dut (
    .CP(CP), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .q_in(q_in), .j_out(j_out), .k_out(k_out), .done(done), .err(err), .mismatch(mismatch)
  );

  jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) dut_t (
    .CP(CP), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_t), .tgt_data(tgt_data),
    .q_in(q_in_t), .j_out(j_t), .k_out(k_t), .done(done_t), .err(err_t),
    .mismatch(mismatch_t)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] v);
    bank_load = 1'b1;
    load_val  = v;
    @(negedge CP);
    bank_load = 1'b0;
  endtask

  typedef struct {
    logic [3:0] q0;
    logic [3:0] tgt;
    logic [3:0] ej;
    logic [3:0] ek;
    logic [3:0] ejt;
    logic [3:0] emis;
    logic [3:0] stuck;
  } vec_t;

  vec_t vecs[5];

  int hs_at[2];
  int nhs, ndone, nerr;

  initial begin
    vecs[0] = '{q0: 4'b0000, tgt: 4'b1010, ej: 4'b1010, ek: 4'b0000, ejt: 4'b1010,
                emis: 4'b0000, stuck: 4'b0000};
    vecs[1] = '{q0: 4'b1100, tgt: 4'b0110, ej: 4'b0010, ek: 4'b1000, ejt: 4'b1010,
                emis: 4'b0000, stuck: 4'b0000};
    vecs[2] = '{q0: 4'b1111, tgt: 4'b1111, ej: 4'b0000, ek: 4'b0000, ejt: 4'b0000,
                emis: 4'b0000, stuck: 4'b0000};
    vecs[3] = '{q0: 4'b0101, tgt: 4'b1010, ej: 4'b1010, ek: 4'b0101, ejt: 4'b1111,
                emis: 4'b0000, stuck: 4'b0000};
    vecs[4] = '{q0: 4'b0000, tgt: 4'b0001, ej: 4'b0001, ek: 4'b0000, ejt: 4'b0001,
                emis: 4'b0001, stuck: 4'b0001};

    // Reset with a simultaneous offered target: reset must win.
    rst        = 1'b1;
    tgt_valid  = 1'b1;
    tgt_data   = 4'b1111;
    bank_load  = 1'b1;
    load_val   = 4'b0000;
    stuck_mask = 4'b0000;
    @(negedge CP);
    @(negedge CP);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_j", j_out, 0);
    chk("rst_k", k_out, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mismatch", mismatch, 0);
    rst       = 1'b0;
    tgt_valid = 1'b0;
    bank_load = 1'b0;
    @(negedge CP);
    chk("post_rst_ready", tgt_ready, 1);

    for (int v = 0; v < 5; v++) begin
      stuck_mask = vecs[v].stuck;
      preload(vecs[v].q0);
      chk($sformatf("v%0d_idle_ready", v), tgt_ready, 1);
      tgt_valid = 1'b1;
      tgt_data  = vecs[v].tgt;
      @(negedge CP);
      tgt_valid = 1'b0;
      tgt_data  = ~vecs[v].tgt;
      chk($sformatf("v%0d_drive_j", v), j_out, vecs[v].ej);
      chk($sformatf("v%0d_drive_k", v), k_out, vecs[v].ek);
      chk($sformatf("v%0d_drive_jt", v), j_t, vecs[v].ejt);
      chk($sformatf("v%0d_drive_kt", v), k_t, vecs[v].ejt);
      chk($sformatf("v%0d_drive_ready", v), tgt_ready, 0);
      @(negedge CP);
      chk($sformatf("v%0d_check_q", v), q_in, vecs[v].tgt ^ vecs[v].emis);
      chk($sformatf("v%0d_check_qt", v), q_in_t, vecs[v].tgt);
      chk($sformatf("v%0d_check_jk", v), {j_out, k_out}, 0);
      @(negedge CP);
      chk($sformatf("v%0d_resp_flags", v), {done, err}, 0);
      @(negedge CP);
      chk($sformatf("v%0d_done", v), done, vecs[v].emis == 4'b0000);
      chk($sformatf("v%0d_err", v), err, vecs[v].emis != 4'b0000);
      chk($sformatf("v%0d_mismatch", v), mismatch, vecs[v].emis);
      chk($sformatf("v%0d_done_t", v), {done_t, err_t}, 2'b10);
      chk($sformatf("v%0d_end_ready", v), tgt_ready, 1);
      @(negedge CP);
      chk($sformatf("v%0d_pulse_end", v), {done, err, done_t, err_t}, 0);
    end
    stuck_mask = 4'b0000;

    // Reset during DRIVE aborts the load.
    preload(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b1111;
    @(negedge CP);
    tgt_valid = 1'b0;
    chk("rdrv_j_before", j_out, 4'b1111);
    rst = 1'b1;
    @(negedge CP);
    rst = 1'b0;
    chk("rdrv_jk", {j_out, k_out}, 0);
    chk("rdrv_ready", tgt_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CP);
      chk($sformatf("rdrv_quiet%0d", i), {done, err}, 0);
    end

    // Reset during RESP suppresses the pending pulse.
    preload(4'b0000);
    tgt_valid = 1'b1;
    tgt_data  = 4'b0011;
    @(negedge CP);
    tgt_valid = 1'b0;
    @(negedge CP);
    @(negedge CP);
    rst = 1'b1;
    @(negedge CP);
    rst = 1'b0;
    chk("rresp_flags", {done, err}, 0);
    chk("rresp_mismatch", mismatch, 0);
    chk("rresp_ready", tgt_ready, 1);
    @(negedge CP);
    chk("rresp_quiet", {done, err}, 0);

    // tgt_valid held high: back-to-back targets, 4 cycles apart.
    preload(4'b0000);
    nhs       = 0;
    ndone     = 0;
    nerr      = 0;
    tgt_valid = 1'b1;
    tgt_data  = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      if (tgt_valid && tgt_ready && nhs < 2) begin
        hs_at[nhs] = i;
        nhs++;
      end
      if (done) ndone++;
      if (err) nerr++;
      @(negedge CP);
      if (nhs == 1) tgt_data = 4'b0101;
      if (nhs == 2) tgt_valid = 1'b0;
    end
    chk("b2b_handshakes", nhs, 2);
    chk("b2b_spacing", hs_at[1] - hs_at[0], 4);
    chk("b2b_done", ndone, 2);
    chk("b2b_err", nerr, 0);
    chk("b2b_final_q", q_in, 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
